// File: rtl/mux_skid8_if.sv
// Valid/ready handshake bundle between the 2:1 data mux and its registered skid stage.
// Optional parity output qp exists only when MUX_SKID8_PARITY_EN is defined.
interface mux_skid8_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             dv;
  logic             dr;
  logic [WIDTH-1:0] q;
  logic             qv;
  logic             qr;
`ifdef MUX_SKID8_PARITY_EN
  logic             qp;

  modport master (output d, output dv, input dr, input q, input qv, input qp, output qr);
  modport slave  (input d, input dv, output dr, output q, output qv, output qp, input qr);
`else
  modport master (output d, output dv, input dr, input q, input qv, output qr);
  modport slave  (input d, input dv, output dr, output q, output qv, input qr);
`endif
endinterface

// File: rtl/mux_skid8.sv
// Registered 2-entry skid stage behind the 8-bit 2:1 data mux; all outputs registered.
// Optional feature: define MUX_SKID8_PARITY_EN to carry per-word even parity on qp.
module mux_skid8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_skid8_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             qv_q, qv_d;
  logic             dr_q, dr_d;
  logic             in_xfer_c;
  logic             out_xfer_c;

`ifdef MUX_SKID8_PARITY_EN
  logic qp_q, qp_d;
  logic skid_p_q, skid_p_d;
  logic d_par_c;

  assign d_par_c = ^bus.d;
`endif

  assign in_xfer_c  = bus.dv & dr_q;
  assign out_xfer_c = qv_q & bus.qr;

  // Next-state and next-output decode; everything defaults to hold.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    skid_d  = skid_q;
    qv_d    = qv_q;
    dr_d    = dr_q;
`ifdef MUX_SKID8_PARITY_EN
    qp_d     = qp_q;
    skid_p_d = skid_p_q;
`endif
    unique case (state_q)
      EMPTY: begin
        qv_d = 1'b0;
        dr_d = 1'b1;
        if (in_xfer_c) begin
          q_d     = bus.d;
          qv_d    = 1'b1;
          state_d = ONE;
`ifdef MUX_SKID8_PARITY_EN
          qp_d = d_par_c;
`endif
        end
      end
      ONE: begin
        if (in_xfer_c && out_xfer_c) begin
          // Drain and refill on the same edge keeps the stream bubble-free.
          q_d = bus.d;
`ifdef MUX_SKID8_PARITY_EN
          qp_d = d_par_c;
`endif
        end else if (in_xfer_c) begin
          skid_d  = bus.d;
          dr_d    = 1'b0;
          state_d = FULL;
`ifdef MUX_SKID8_PARITY_EN
          skid_p_d = d_par_c;
`endif
        end else if (out_xfer_c) begin
          qv_d    = 1'b0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer_c) begin
          q_d     = skid_q;
          dr_d    = 1'b1;
          state_d = ONE;
`ifdef MUX_SKID8_PARITY_EN
          qp_d = skid_p_q;
`endif
        end
      end
      default: begin
        // Illegal encoding recovers to the reset image.
        state_d = EMPTY;
        q_d     = '0;
        skid_d  = '0;
        qv_d    = 1'b0;
        dr_d    = 1'b1;
`ifdef MUX_SKID8_PARITY_EN
        qp_d     = 1'b0;
        skid_p_d = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      q_q     <= '0;
      skid_q  <= '0;
      qv_q    <= 1'b0;
      dr_q    <= 1'b1;
`ifdef MUX_SKID8_PARITY_EN
      qp_q     <= 1'b0;
      skid_p_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      skid_q  <= skid_d;
      qv_q    <= qv_d;
      dr_q    <= dr_d;
`ifdef MUX_SKID8_PARITY_EN
      qp_q     <= qp_d;
      skid_p_q <= skid_p_d;
`endif
    end
  end

  assign bus.q  = q_q;
  assign bus.qv = qv_q;
  assign bus.dr = dr_q;
`ifdef MUX_SKID8_PARITY_EN
  assign bus.qp = qp_q;
`endif

endmodule

// File: tb/tb_mux_skid8.sv
// Self-checking bench for mux_skid8: FIFO-queue model checked every cycle plus directed literals.
// Define MUX_SKID8_PARITY_EN to also cover the qp output.
module tb_mux_skid8;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_skid8_if #(.WIDTH(WIDTH)) bus ();

  mux_skid8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a FIFO of at most two words, each stored with its parity bit on top.
  logic [WIDTH:0] model_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit do_out;
      bit do_in;
      do_out = (model_q.size() > 0) && bus.qr;
      do_in  = bus.dv && (model_q.size() < 2);
      if (do_out) void'(model_q.pop_front());
      if (do_in)  model_q.push_back({^bus.d, bus.d});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [WIDTH:0] head;
      head = (model_q.size() > 0) ? model_q[0] : '0;
      check("model_qv", 32'(bus.qv), 32'(model_q.size() > 0));
      check("model_dr", 32'(bus.dr), 32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        check("model_q", 32'(bus.q), 32'(head[WIDTH-1:0]));
`ifdef MUX_SKID8_PARITY_EN
        check("model_qp", 32'(bus.qp), 32'(head[WIDTH]));
`endif
      end
    end
  end

  task automatic cycle(input logic dv, input logic [WIDTH-1:0] d, input logic qr);
    bus.dv = dv;
    bus.d  = d;
    bus.qr = qr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.dv   = 1'b0;
    bus.d    = '0;
    bus.qr   = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_qv", 32'(bus.qv), 32'd0);
    check("reset_dr", 32'(bus.dr), 32'd1);
    check("reset_q",  32'(bus.q),  32'h00);

    // Single transfer
    cycle(1'b1, 8'h3C, 1'b1);
    check("single_q",  32'(bus.q),  32'h3C);
    check("single_qv", 32'(bus.qv), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("single_drain_qv", 32'(bus.qv), 32'd0);

    // Streaming 01..10 with one-cycle latency
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b1);
      check("stream_q",  32'(bus.q),  32'(i));
      check("stream_dr", 32'(bus.dr), 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("stream_end_qv", 32'(bus.qv), 32'd0);

    // Backpressure
    cycle(1'b1, 8'h11, 1'b0);
    check("bp_one_dr", 32'(bus.dr), 32'd1);
    cycle(1'b1, 8'h22, 1'b0);
    check("bp_full_dr", 32'(bus.dr), 32'd0);
    check("bp_full_q",  32'(bus.q),  32'h11);
    cycle(1'b1, 8'h33, 1'b0);
    check("bp_hold_q",  32'(bus.q),  32'h11);
    check("bp_hold_dr", 32'(bus.dr), 32'd0);
    cycle(1'b1, 8'h33, 1'b1);
    check("bp_out2_q", 32'(bus.q),  32'h22);
    check("bp_out2_dr", 32'(bus.dr), 32'd1);
    cycle(1'b1, 8'h33, 1'b1);
    check("bp_out3_q", 32'(bus.q), 32'h33);
    cycle(1'b0, 8'h00, 1'b1);
    check("bp_drain_qv", 32'(bus.qv), 32'd0);

    // Simultaneous accept and drain in ONE
    cycle(1'b1, 8'h44, 1'b0);
    check("sim_pre_q", 32'(bus.q), 32'h44);
    cycle(1'b1, 8'h55, 1'b1);
    check("sim_q",  32'(bus.q),  32'h55);
    check("sim_dr", 32'(bus.dr), 32'd1);
    check("sim_qv", 32'(bus.qv), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Parity words
    cycle(1'b1, 8'h07, 1'b1);
    check("par_q7", 32'(bus.q), 32'h07);
`ifdef MUX_SKID8_PARITY_EN
    check("par_qp7", 32'(bus.qp), 32'd1);
`endif
    cycle(1'b1, 8'h03, 1'b1);
    check("par_q3", 32'(bus.q), 32'h03);
`ifdef MUX_SKID8_PARITY_EN
    check("par_qp3", 32'(bus.qp), 32'd0);
`endif
    cycle(1'b0, 8'h00, 1'b1);

    // Mixed pattern with alternating backpressure
    for (int i = 0; i < 24; i++) begin
      cycle(1'(i % 3 != 2), 8'(8'h80 + i * 7), 1'(i % 4 < 2));
    end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle while FULL with q=A5
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    check("pre_rst_q",  32'(bus.q),  32'hA5);
    check("pre_rst_dr", 32'(bus.dr), 32'd0);
    bus.dv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q",  32'(bus.q),  32'h00);
    check("async_rst_qv", 32'(bus.qv), 32'd0);
    check("async_rst_dr", 32'(bus.dr), 32'd1);
`ifdef MUX_SKID8_PARITY_EN
    check("async_rst_qp", 32'(bus.qp), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h66, 1'b1);
    check("post_rst_q", 32'(bus.q), 32'h66);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_rst_qv", 32'(bus.qv), 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
